// File: rtl/muldiv_unit_if.sv
// Bus bundle between the EX-stage controller and the multiply/divide unit.
// The controller side uses the master modport, the unit uses the slave modport.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Multiply: one shift-add step per cycle on operand magnitudes.
// Divide: one restoring shift-subtract step per cycle on operand magnitudes.
// Signs are fixed up in a final FIX cycle that also writes HI/LO and pulses done.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies finish as soon as the
// remaining multiplier bits are all zero (division keeps its fixed latency).
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    // Two's-complement negate when cond is set (WIDTH bits).
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic cond);
        if (cond) begin
            cond_neg = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cond_neg = v;
        end
    endfunction

    // Two's-complement negate when cond is set (2*WIDTH bits).
    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic cond);
        if (cond) begin
            cond_neg2 = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cond_neg2 = v;
        end
    endfunction

    // Magnitude of an operand: absolute value for signed ops, raw for unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        magnitude = cond_neg(v, is_signed & v[WIDTH-1]);
    endfunction

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;        // product, or {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] opnd_q, opnd_d;      // shifted multiplicand, or divisor in low half
    logic [WIDTH-1:0]   mplier_q, mplier_d;  // remaining multiplier bits
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               zero_div_q, zero_div_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;    // unmodified dividend for divide-by-zero HI
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               flag_q, flag_d;

    logic [2*WIDTH-1:0] mul_acc_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH:0]     diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic               early_s;
    logic               last_s;

    // Datapath step values for the current cycle.
    always_comb begin
        mul_acc_s = acc_q + (mplier_q[0] ? opnd_q : {(2*WIDTH){1'b0}});
        rem_sh_s  = acc_q[2*WIDTH-1:WIDTH-1];
        diff_s    = rem_sh_s - {1'b0, opnd_q[WIDTH-1:0]};
        prod_s    = cond_neg2(acc_q, neg_res_q);
`ifdef MULDIV_EARLY_OUT_EN
        early_s   = (mplier_q[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
        early_s   = 1'b0;
`endif
        last_s    = (cnt_q == CNT_ONE);
    end

    // Next-state and datapath control for the IDLE/MUL/DIV/FIX sequencer.
    always_comb begin
        state_d    = state_q;
        is_div_d   = is_div_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        zero_div_d = zero_div_q;
        a_raw_d    = a_raw_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        flag_d     = flag_q;

        case (state_q)
            S_IDLE: begin
                // Register moves only act while idle; a same-cycle start
                // later overwrites them with its result.
                if (bus.mthi) begin
                    hi_d = bus.a;
                end else begin
                    hi_d = hi_q;
                end
                if (bus.mtlo) begin
                    lo_d = bus.a;
                end else begin
                    lo_d = lo_q;
                end
                if (bus.start) begin
                    is_div_d  = bus.op[1];
                    cnt_d     = CNT_INIT;
                    flag_d    = 1'b0;
                    a_raw_d   = bus.a;
                    neg_res_d = bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    if (bus.op[1]) begin
                        acc_d      = {{WIDTH{1'b0}}, magnitude(bus.a, bus.op[0])};
                        opnd_d     = {{WIDTH{1'b0}}, magnitude(bus.b, bus.op[0])};
                        mplier_d   = {WIDTH{1'b0}};
                        neg_rem_d  = bus.op[0] & bus.a[WIDTH-1];
                        zero_div_d = (bus.b == {WIDTH{1'b0}});
                        state_d    = S_DIV;
                    end else begin
                        acc_d      = {(2*WIDTH){1'b0}};
                        opnd_d     = {{WIDTH{1'b0}}, magnitude(bus.a, bus.op[0])};
                        mplier_d   = magnitude(bus.b, bus.op[0]);
                        neg_rem_d  = 1'b0;
                        zero_div_d = 1'b0;
                        state_d    = S_MUL;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                acc_d    = mul_acc_s;
                opnd_d   = {opnd_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q - CNT_ONE;
                if (last_s || early_s) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_DIV: begin
                // Quotient bit is 1 when the shifted remainder covers the divisor.
                if (!diff_s[WIDTH]) begin
                    acc_d = {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_ONE;
                if (last_s) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    if (zero_div_q) begin
                        lo_d   = {WIDTH{1'b1}};
                        hi_d   = a_raw_q;
                        flag_d = 1'b1;
                    end else begin
                        lo_d   = cond_neg(acc_q[WIDTH-1:0], neg_res_q);
                        hi_d   = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
                        flag_d = 1'b0;
                    end
                end else begin
                    hi_d   = prod_s[2*WIDTH-1:WIDTH];
                    lo_d   = prod_s[WIDTH-1:0];
                    flag_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_div_q   <= 1'b0;
            acc_q      <= {(2*WIDTH){1'b0}};
            opnd_q     <= {(2*WIDTH){1'b0}};
            mplier_q   <= {WIDTH{1'b0}};
            cnt_q      <= {CW{1'b0}};
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_div_q <= 1'b0;
            a_raw_q    <= {WIDTH{1'b0}};
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_div_q   <= is_div_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            zero_div_q <= zero_div_d;
            a_raw_q    <= a_raw_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            flag_q     <= flag_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = flag_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    muldiv_unit_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Returns {div_by_zero, hi, lo} from the arithmetic definition of each op.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin
                p = {32'd0, a} * {32'd0, b};
                return {1'b0, p};
            end
            2'd1: begin
                p = sa * sb;
                return {1'b0, p};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (op == 2'd2) return {1'b0, a % b, a / b};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Waits for done with a cycle bound; lat counts edges after the start edge.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("done_timeout", bus.done, 1'b1);
    endtask

    task automatic pulse_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op = 2'($urandom);
        bus.a = $urandom;
        bus.b = $urandom;
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                         output int lat, output bit busy_ok);
        pulse_start(op, a, b);
        wait_done(lat, busy_ok);
        check({tag, "_hi"}, bus.hi, ehi);
        check({tag, "_lo"}, bus.lo, elo);
        check({tag, "_dbz"}, bus.div_by_zero, edbz);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_1cyc"}, bus.done, 1'b0);
    endtask

    initial begin
        int lat;
        bit busy_ok;
        logic [64:0] e;
        logic [1:0] rop;
        logic [31:0] ra, rb;

        bus.start = 1'b0; bus.op = 2'd0; bus.a = 32'd0; bus.b = 32'd0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_dbz", bus.div_by_zero, 1'b0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        reset = 1'b0;

        // 1: full-width MULTU, latency and busy
        do_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, lat, busy_ok);
        check("multu_busy_held", busy_ok, 1'b1);
`ifndef MULDIV_EARLY_OUT_EN
        check("multu_latency", lat, 33);
`endif

        // 2: signed multiply
        do_op("mult_neg", 2'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, lat, busy_ok);
        do_op("mult_min", 2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, lat, busy_ok);

        // 3: divide
        do_op("divu_100_7", 2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, lat, busy_ok);
        do_op("div_m7_2", 2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, lat, busy_ok);

        // 4: divide by zero and signed overflow
        do_op("divu_by0", 2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, lat, busy_ok);
        do_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, lat, busy_ok);
        do_op("div_by0_s", 2'd3, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, lat, busy_ok);
        do_op("mult_clr_dbz", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, lat, busy_ok);

        // 5: start and mthi while busy are ignored
        pulse_start(2'd0, 32'h0001_0001, 32'h0003_0003);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd2; bus.a = 32'h1234; bus.b = 32'd1; bus.mthi = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.mthi = 1'b0;
        wait_done(lat, busy_ok);
        check("busy_ign_hi", bus.hi, 32'h0000_0003);
        check("busy_ign_lo", bus.lo, 32'h0006_0003);
        @(negedge clk);
        check("no_queue_busy", bus.busy, 1'b0);
        bus.mthi = 1'b1; bus.a = 32'hABCD;
        @(negedge clk);
        bus.mthi = 1'b0;
        check("mthi_hi", bus.hi, 32'hABCD);
        check("mthi_lo_kept", bus.lo, 32'h0006_0003);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.a = 32'h55AA;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        check("mthilo_hi", bus.hi, 32'h55AA);
        check("mthilo_lo", bus.lo, 32'h55AA);

        // same-cycle start + mtlo: result wins
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd9; bus.b = 32'd9; bus.mtlo = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.mtlo = 1'b0;
        check("mtlo_with_start", bus.lo, 32'd9);
        wait_done(lat, busy_ok);
        check("start_mtlo_lo", bus.lo, 32'd81);

        // 6: asynchronous reset mid-divide
        pulse_start(2'd3, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", bus.busy, 1'b0);
        check("arst_done", bus.done, 1'b0);
        check("arst_hi", bus.hi, 32'd0);
        check("arst_lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_op("divu_9_3", 2'd2, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, lat, busy_ok);

        // random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'd1;
                3: rb = 32'($urandom_range(2, 300));
                4: ra = 32'h8000_0000;
                5: rb = rb >> $urandom_range(1, 31);
                default: ;
            endcase
            e = model(rop, ra, rb);
            do_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, e[63:32], e[31:0], e[64], lat, busy_ok);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the EX stage, parallel to the main ALU.
- Consumes the same register operands (srca/srcb) as the ALU and holds results in architectural HI/LO registers.
- HI/LO are read by mfhi/mflo through the writeback mux.
- Controller starts an operation with a start pulse, then stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand width; hi/lo are each WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin operation; sampled only in IDLE.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  WIDTH  multiplicand / dividend (rs).
- b  input  WIDTH  multiplier / divisor (rt).
- mthi  input  1  write a into HI.
- mtlo  input  1  write a into LO.
- busy  output  1  operation in progress; pipeline stall request.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- div_by_zero  output  1  valid with done; set when a DIV/DIVU had b==0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; all internal registers cleared. Reset mid-operation aborts the operation with no partial HI/LO update.
- States: IDLE, MUL, DIV, FIX.
  - IDLE: start=1 latches op, |a|, |b| (magnitudes for signed ops; raw for unsigned), result-sign and remainder-sign bits. Loads iteration counter = WIDTH. Goes to MUL (op[1]=0) or DIV (op[1]=1).
  - MUL: one shift-add step per cycle into a 2*WIDTH accumulator. Counter decrements; at counter==1 go to FIX.
  - DIV: one restoring shift-subtract step per cycle (quotient bit 1 when partial remainder >= divisor). Counter decrements; at counter==1 go to FIX.
  - FIX: apply two's-complement sign correction, write HI/LO, pulse done, return to IDLE.
- busy=1 in MUL, DIV and FIX; busy=0 in IDLE.
- Latency: start sampled at edge N; HI/LO updated and done=1 during the cycle after edge N+WIDTH+1 (34 cycles for WIDTH=32). done lasts exactly one cycle.
- Results:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product. MULT negates the product when operand signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed DIV truncates toward zero: quotient negated when signs differ; remainder takes the dividend's sign.
  - Signed overflow: DIV with a=most-negative, b=-1 gives lo=a, hi=0, no flag.
- Divide by zero: still takes full latency. lo={WIDTH{1}}, hi=a (unmodified, also for signed ops), div_by_zero=1 with done. div_by_zero clears on the next start.
- start while busy: ignored, no queuing.
- mthi/mtlo: take effect at the edge only when busy=0; ignored while busy.
  - Same-cycle start+mthi/mtlo in IDLE: both act; the later operation result overwrites HI/LO.
  - mthi and mtlo together write a into both registers.
- Inputs a, b, op are only required to be stable in the start cycle.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in MUL, when the remaining unshifted multiplier bits are all zero, go to FIX on the next edge. Minimum multiply latency is 3 cycles (b==0 or b==1). Division is unaffected.
- Undefined: fixed latency as above. Benches must synchronise on done, never on cycle counts, except the fixed-latency check in scenario 1, which is compiled only without the macro.

Test Plan:
1. Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after start; busy high throughout.
2. MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
3. DIVU a=100 b=7 -> lo=14, hi=2. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
4. DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
5. Second start and mthi (a=0x1234) pulsed mid-MULTU -> both ignored, first result intact. mthi a=0xABCD in IDLE -> hi=0xABCD next cycle, lo unchanged.
6. Assert reset 10 cycles into a DIV -> busy, done, hi, lo drop to 0 immediately (asynchronously). A subsequent DIVU 9/3 gives lo=3, hi=0.
